// File: rtl/pixel_substitution_if.sv
// Pixel-in / cipher-out stream bundle for pixel_substitution.
// master = pixel source and cipher sink, slave = the substitution block.
interface pixel_substitution_if;
    logic       pix_valid;
    logic [7:0] pix_data;
    logic       pix_last;
    logic [7:0] key_byte;
    logic       pix_ready;
    logic       cipher_valid;
    logic [7:0] cipher_data;
    logic       cipher_last;
    logic       cipher_ready;

    modport master (
        output pix_valid, pix_data, pix_last, key_byte, cipher_ready,
        input  pix_ready, cipher_valid, cipher_data, cipher_last
    );

    modport slave (
        input  pix_valid, pix_data, pix_last, key_byte, cipher_ready,
        output pix_ready, cipher_valid, cipher_data, cipher_last
    );
endinterface

// File: rtl/pixel_substitution.sv
// Chained S-box pixel substitution: cipher = S[pixel ^ key] ^ prev.
// The table is filled in LOAD and frozen once RUN is entered.
module pixel_substitution #(
    parameter logic [7:0] IV = 8'hA5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sbox_wr_en,
    input  logic [7:0]               sbox_wr_addr,
    input  logic [7:0]               sbox_wr_data,
    input  logic                     done_sbox,
    pixel_substitution_if.slave      bus,
    output logic                     running,
    output logic                     frame_done,
    output logic [15:0]              pix_count
);
    typedef enum logic {LOAD, RUN} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  sbox [256];
    logic [7:0]  prev;
    logic [7:0]  cipher_nxt;
    logic        accept;
    logic        c_valid;
    logic [7:0]  c_data;
    logic        c_last;

    assign running          = (state == RUN);
    assign bus.pix_ready    = running & (~c_valid | bus.cipher_ready);
    assign accept           = bus.pix_valid & bus.pix_ready;
    assign cipher_nxt       = sbox[bus.pix_data ^ bus.key_byte] ^ prev;
    assign bus.cipher_valid = c_valid;
    assign bus.cipher_data  = c_data;
    assign bus.cipher_last  = c_last;

    // State register; reset always returns to table loading.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: leave LOAD once the generator is done, RUN is sticky.
    always_comb begin
        state_nxt = state;
        unique case (state)
            LOAD: if (done_sbox) state_nxt = RUN;
            RUN:  state_nxt = RUN;
        endcase
    end

    // S-box table write port, open only while loading; not reset.
    always_ff @(posedge clk) begin
        if (state == LOAD && sbox_wr_en) begin
            sbox[sbox_wr_addr] <= sbox_wr_data;
        end
    end

    // Cipher output register, chaining value, pixel counter, frame pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            c_valid    <= 1'b0;
            c_data     <= 8'h00;
            c_last     <= 1'b0;
            prev       <= IV;
            pix_count  <= 16'h0000;
            frame_done <= 1'b0;
        end else begin
            frame_done <= c_valid & bus.cipher_ready & c_last;
            if (accept) begin
                c_valid   <= 1'b1;
                c_data    <= cipher_nxt;
                c_last    <= bus.pix_last;
                prev      <= bus.pix_last ? IV : cipher_nxt;
                pix_count <= bus.pix_last ? 16'h0000 : pix_count + 16'd1;
            end else if (bus.cipher_ready) begin
                c_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/pixel_substitution.md
PIXEL_SUBSTITUTION -- requirements
Module: pixel_substitution

Interface
REQ-001 Parameter IV, default 8'hA5: chaining seed, applied at frame start and after every last pixel.
REQ-002 clk  input  1  rising-edge clock; all state changes on this edge.
REQ-003 rst  input  1  synchronous active-low reset; sampled on the rising edge of clk.
REQ-004 sbox_wr_en  input  1  S-box table write strobe from the S-box generator.
REQ-005 sbox_wr_addr  input  8  S-box entry index.
REQ-006 sbox_wr_data  input  8  S-box entry value.
REQ-007 done_sbox  input  1  S-box generation complete (level or pulse).
REQ-008 pix_valid  input  1  plaintext pixel offered.
REQ-009 pix_data  input  8  plaintext pixel byte.
REQ-010 pix_last  input  1  final pixel of frame; qualified by pix_valid.
REQ-011 key_byte  input  8  chaotic keystream byte; sampled with the pixel.
REQ-012 pix_ready  output  1  block accepts the pixel this cycle.
REQ-013 cipher_valid  output  1  cipher byte available.
REQ-014 cipher_data  output  8  cipher byte.
REQ-015 cipher_last  output  1  cipher byte is last of frame.
REQ-016 cipher_ready  input  1  downstream accepts the cipher byte.
REQ-017 running  output  1  high in RUN state.
REQ-018 frame_done  output  1  one-cycle pulse on cipher_last handshake.
REQ-019 pix_count  output  16  accepted pixels in current frame.

Function
REQ-020 Two states: LOAD and RUN; the block SHALL enter LOAD after reset.
REQ-021 LOAD: sbox_wr_en SHALL write sbox_wr_data into the 256x8 table at sbox_wr_addr; pix_ready=0.
REQ-022 LOAD->RUN on the cycle after done_sbox=1; a write in that same cycle SHALL be committed.
REQ-023 RUN: sbox_wr_en SHALL be ignored; the table is frozen; the block stays in RUN regardless of done_sbox until reset.
REQ-024 Pixel accept = pix_valid & pix_ready; pix_ready = RUN & (!cipher_valid | cipher_ready).
REQ-025 On accept: cipher = S[pix_data ^ key_byte] ^ prev; prev SHALL update to cipher.
REQ-026 prev SHALL equal IV at reset and after accepting a pixel with pix_last=1.
REQ-027 Latency: cipher_valid SHALL rise the cycle after accept, with cipher_data/cipher_last registered.
REQ-028 cipher_valid, cipher_data and cipher_last SHALL hold stable while cipher_valid=1 and cipher_ready=0.
REQ-029 cipher_valid SHALL clear after handshake unless a new pixel is accepted the same cycle; back-to-back throughput is 1 byte/cycle.
REQ-030 pix_count SHALL increment on each accept, wrap 0xFFFF->0x0000, and be set to 0 on the cycle after a pix_last accept.
REQ-031 frame_done SHALL pulse for one cycle the cycle after cipher_valid & cipher_ready & cipher_last.
REQ-032 All arithmetic is 8-bit XOR; no carries.

Reset
REQ-033 While rst=0 on a clock edge: state=LOAD, pix_ready=0, cipher_valid=0, cipher_data=0, cipher_last=0, running=0, frame_done=0, pix_count=0, prev=IV.
REQ-034 Table contents are not cleared by reset; they SHALL be rewritten in LOAD before use.
REQ-035 Reset mid-frame SHALL discard any pending cipher byte and in-progress chain state.

Verification
REQ-036 Identity S-box (S[i]=i), done_sbox; key 0x00; pixels 0x10, 0x20 -> cipher 0xB5, 0x95.
REQ-037 S[i]=~i; pixel 0x00 with key 0x0F -> cipher 0x55.
REQ-038 Identity S-box, key 0; pixel 0x10 with last=1, then 0x10 -> cipher 0xB5, 0xB5; frame_done pulses once; pix_count returns to 0.
REQ-039 cipher_ready=0 for 5 cycles with pix_valid=1 -> cipher_data held, pix_ready=0, no pixel lost or duplicated.
REQ-040 In RUN, write S[0x10]=0xFF -> ignored; pixel 0x10, key 0 -> cipher still 0xB5.
REQ-041 rst=0 mid-frame with cipher_valid=1 -> all outputs at reset values the next cycle; state=LOAD; pix_ready=0 until a new done_sbox.
